// File: rtl/dl_xor_chksum_pkg.sv
// -----------------------------------------------------------------------------
// dl_xor_chksum_pkg
// Shared definitions for the XOR-fold checksum accumulator:
//   - state_e   : FSM state encoding (IDLE=0, ACC=1, OUT=2)
//   - handshake : valid & ready transfer qualifier
// -----------------------------------------------------------------------------
`ifndef DL_XOR_CHKSUM_PKG_SV
`define DL_XOR_CHKSUM_PKG_SV

package dl_xor_chksum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // A beat or result moves only on a cycle where both sides agree.
  function automatic logic handshake(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

`endif

// File: rtl/dl_xor.sv
// -----------------------------------------------------------------------------
// dl_xor
// Bitwise XOR of two NUM_BITS-wide operands (purely combinational).
// Ports:
//   a_i  in  NUM_BITS  first operand
//   b_i  in  NUM_BITS  second operand
//   y_o  out NUM_BITS  a_i ^ b_i
// -----------------------------------------------------------------------------
module dl_xor #(
  parameter int NUM_BITS = 32
) (
  input  logic [NUM_BITS-1:0] a_i,
  input  logic [NUM_BITS-1:0] b_i,
  output logic [NUM_BITS-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/dl_xor_chksum.sv
// -----------------------------------------------------------------------------
// dl_xor_chksum
// Streaming XOR-fold checksum. Words of a packet arrive over a valid/ready
// input, are folded into a running XOR register seeded with SEED, and one
// checksum word per packet is presented over a valid/ready output.
//
// Ports:
//   clk         in   1         clock, rising edge
//   rst         in   1         synchronous active-high reset
//   in_valid    in   1         input beat valid
//   in_ready    out  1         block can accept a beat
//   in_data     in   NUM_BITS  input word
//   in_last     in   1         final beat of packet (qualified by in_valid)
//   out_valid   out  1         checksum available
//   out_ready   in   1         consumer accepts checksum
//   out_chksum  out  NUM_BITS  SEED ^ all words of the packet
//   out_err     out  1         beat counter saturated during the packet
//   out_cnt     out  CNT_BITS  beats in packet (only with DL_XOR_CHKSUM_CNT_EN)
//
// Optional feature macro: DL_XOR_CHKSUM_CNT_EN adds the out_cnt port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge; out_chksum/out_err (and out_cnt) are held stable while out_valid is
// high and out_ready is low. Outputs read as zero whenever out_valid is low.
// -----------------------------------------------------------------------------
module dl_xor_chksum
  import dl_xor_chksum_pkg::*;
#(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] SEED     = '0,
  parameter int                  CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_chksum,
  output logic                out_err
`ifdef DL_XOR_CHKSUM_CNT_EN
  ,
  output logic [CNT_BITS-1:0] out_cnt
`endif
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] acc_q, acc_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_BITS-1:0] xor_a;
  logic [NUM_BITS-1:0] xor_y;
  logic                in_fire;
  logic                out_fire;
  logic                in_state;

  // Readiness is a pure function of state, gated off during reset so no beat
  // can slip in on the reset edge.
  assign in_state  = (state_q == ST_IDLE) || (state_q == ST_ACC);
  assign in_ready  = in_state && !rst;
  assign out_valid = (state_q == ST_OUT) && !rst;
  assign in_fire   = handshake(in_valid, in_ready);
  assign out_fire  = handshake(out_valid, out_ready);

  // The first beat of a packet folds against SEED rather than the stale
  // accumulator, so IDLE never needs a separate reload cycle.
  assign xor_a = (state_q == ST_IDLE) ? SEED : acc_q;

  dl_xor #(
    .NUM_BITS(NUM_BITS)
  ) u_xor (
    .a_i(xor_a),
    .b_i(in_data),
    .y_o(xor_y)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          acc_d   = xor_y;
          cnt_d   = CNT_ONE;
          err_d   = 1'b0;
          state_d = in_last ? ST_OUT : ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_fire) begin
          acc_d = xor_y;
          // Saturate rather than wrap; a beat arriving at saturation marks
          // the packet length as unrepresentable.
          if (cnt_q == CNT_MAX) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (in_last) begin
            state_d = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_fire) begin
          state_d = ST_IDLE;
          acc_d   = SEED;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        acc_d   = SEED;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= SEED;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Result fields are zero outside OUT; inside OUT they come straight from
  // registers that only change on out_fire, which gives hold stability.
  assign out_chksum = out_valid ? acc_q : '0;
  assign out_err    = out_valid ? err_q : 1'b0;

`ifdef DL_XOR_CHKSUM_CNT_EN
  assign out_cnt = out_valid ? cnt_q : '0;
`endif

`ifndef SYNTHESIS
  a_out_hold : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_chksum) && $stable(out_err)));

  a_excl : assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));
`endif

endmodule

// File: tb/tb_dl_xor_chksum.sv
module tb_dl_xor_chksum;

  localparam int W  = 32;
  localparam int EW = 1 + 8 + W;   // {err, cnt[7:0], chksum}
  localparam logic [W-1:0] SEED_A = 32'h0000_0000;
  localparam logic [W-1:0] SEED_B = 32'hFFFF_FFFF;
  localparam int MAX_A = 255;      // CNT_BITS = 8
  localparam int MAX_B = 3;        // CNT_BITS = 2

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_last, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready_a, out_valid_a, out_err_a;
  logic         in_ready_b, out_valid_b, out_err_b;
  logic [W-1:0] out_chksum_a, out_chksum_b;
`ifdef DL_XOR_CHKSUM_CNT_EN
  logic [7:0]   out_cnt_a;
  logic [1:0]   out_cnt_b;
`endif

  dl_xor_chksum #(.NUM_BITS(W), .SEED(SEED_A), .CNT_BITS(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_chksum(out_chksum_a), .out_err(out_err_a)
`ifdef DL_XOR_CHKSUM_CNT_EN
    , .out_cnt(out_cnt_a)
`endif
  );

  dl_xor_chksum #(.NUM_BITS(W), .SEED(SEED_B), .CNT_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_chksum(out_chksum_b), .out_err(out_err_b)
`ifdef DL_XOR_CHKSUM_CNT_EN
    , .out_cnt(out_cnt_b)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  logic [W-1:0]  pkt_q[$];
  int bp_mode = 0;   // 0: always ready, 1: hold off, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: checksum is SEED XOR every word; error iff the packet is longer
  // than the counter can represent; count is the length clipped to that max.
  function automatic logic [EW-1:0] model(input logic [W-1:0] seed, input int max_cnt);
    logic [W-1:0] x;
    int len;
    x = seed;
    len = pkt_q.size();
    foreach (pkt_q[i]) x = x ^ pkt_q[i];
    return {(len > max_cnt) ? 1'b1 : 1'b0, 8'((len > max_cnt) ? max_cnt : len), x};
  endfunction

  // ---------------- output back-pressure ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (in_ready_a) ok = 1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: got no in_ready expected in_ready within 500 cycles");
    end
    in_valid = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
    in_data  = $urandom;
  endtask

  // Sends pkt_q; last flag on final word. gap_pct: chance of idle cycles.
  task automatic send_packet(input int gap_pct, input bit complete);
    for (int i = 0; i < pkt_q.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
      send_beat(pkt_q[i], complete && (i == pkt_q.size() - 1));
    end
    if (complete) begin
      exp_a.push_back(model(SEED_A, MAX_A));
      exp_b.push_back(model(SEED_B, MAX_B));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_a, hold_b;

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid_a", 64'(out_valid_a), 64'd1);
          check("hold_chksum_a", 64'(out_chksum_a), 64'(hold_a));
          check("hold_chksum_b", 64'(out_chksum_b), 64'(hold_b));
        end
        hold_v = out_valid_a && !out_ready;
        hold_a = out_chksum_a;
        hold_b = out_chksum_b;
        if (out_valid_a && out_ready) begin
          if (exp_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_a: got %h expected no output", out_chksum_a);
          end else begin
            e = exp_a.pop_front();
            check("chksum_a", 64'(out_chksum_a), 64'(e[W-1:0]));
            check("err_a", 64'(out_err_a), 64'(e[EW-1]));
`ifdef DL_XOR_CHKSUM_CNT_EN
            check("cnt_a", 64'(out_cnt_a), 64'(e[EW-2:W]));
`endif
          end
        end
        if (out_valid_b && out_ready) begin
          if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_b: got %h expected no output", out_chksum_b);
          end else begin
            e = exp_b.pop_front();
            check("chksum_b", 64'(out_chksum_b), 64'(e[W-1:0]));
            check("err_b", 64'(out_err_b), 64'(e[EW-1]));
`ifdef DL_XOR_CHKSUM_CNT_EN
            check("cnt_b", 64'({6'd0, out_cnt_b}), 64'(e[EW-2:W]));
`endif
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int len;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;

    @(negedge clk);
    check("rst_in_ready", 64'(in_ready_a), 64'd0);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_chksum", 64'(out_chksum_a), 64'd0);
    check("rst_err", 64'(out_err_a), 64'd0);
    check("rst_in_ready2", 64'(in_ready_b), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    #1;

    // Three-beat packet, SEED 0 on A.
    pkt_q = '{32'h0000_00FF, 32'h0000_0F0F, 32'h1234_0000};
    send_packet(0, 1'b1);
    @(negedge clk);
    check("t1_latency", 64'(out_valid_a), 64'd1);
    check("t1_chksum", 64'(out_chksum_a), 64'h1234_0FF0);
    check("t1_err", 64'(out_err_a), 64'd0);
    @(posedge clk);
    #1;

    // Single beat; B has SEED all-ones.
    pkt_q = '{32'hDEAD_BEEF};
    send_packet(0, 1'b1);
    @(negedge clk);
    check("t2_chksum_b", 64'(out_chksum_b), 64'h2152_4110);
    check("t2_in_ready_out", 64'(in_ready_b), 64'd0);
    @(posedge clk);
    #1;

    // Output held off for 5 cycles.
    bp_mode = 1;
    pkt_q = '{32'hA5A5_1234, 32'h0F0F_F0F0};
    send_packet(0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("t3_valid", 64'(out_valid_a), 64'd1);
      check("t3_in_ready", 64'(in_ready_a), 64'd0);
    end
    @(posedge clk);
    #1;
    bp_mode = 0;
    pkt_q = '{32'h0000_0077};
    send_packet(0, 1'b1);
    @(negedge clk);
    check("t3_next_chksum", 64'(out_chksum_a), 64'h0000_0077);
    @(posedge clk);
    #1;

    // Counter saturation on B (max 3): 4 beats errs, then 2 beats clean.
    pkt_q = '{32'h1, 32'h2, 32'h4, 32'h8};
    send_packet(0, 1'b1);
    @(negedge clk);
    check("t4_err_b", 64'(out_err_b), 64'd1);
    check("t4_err_a", 64'(out_err_a), 64'd0);
    @(posedge clk);
    #1;
    pkt_q = '{32'h10, 32'h20};
    send_packet(0, 1'b1);
    @(negedge clk);
    check("t4_err_b_clear", 64'(out_err_b), 64'd0);
    @(posedge clk);
    #1;

    // Reset after 2 beats of an unfinished packet.
    pkt_q = '{32'hCAFE_0001, 32'hCAFE_0002};
    send_packet(0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_in_ready", 64'(in_ready_a), 64'd0);
    check("t5_rst_out_valid", 64'(out_valid_a), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_q = '{32'h0000_0005};
    send_packet(0, 1'b1);
    @(negedge clk);
    check("t5_chksum_a", 64'(out_chksum_a), 64'h0000_0005);
    check("t5_chksum_b", 64'(out_chksum_b), 64'hFFFF_FFFA);
    @(posedge clk);
    #1;

    // Random packets with input gaps and output back-pressure.
    bp_mode = 2;
    for (int p = 0; p < 100; p++) begin
      if ($urandom_range(0, 19) == 0) len = $urandom_range(250, 260);
      else len = $urandom_range(1, 6);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back($urandom);
      send_packet(30, 1'b1);
    end

    // Drain.
    bp_mode = 0;
    for (int n = 0; n < 200 && (exp_a.size() != 0 || exp_b.size() != 0); n++) begin
      @(posedge clk);
    end
    @(negedge clk);
    check("drain_a", 64'(exp_a.size()), 64'd0);
    check("drain_b", 64'(exp_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dl_xor_chksum.md
Name: dl_xor_chksum

Overview:
- Streaming XOR-fold checksum accumulator; sits directly downstream of dl_xor and consumes its bitwise result every accepted beat.
- Accepts a packet of NUM_BITS-wide words over a valid/ready input, folds them into a running XOR register, and presents one checksum word per packet on a valid/ready output.
- Used for instruction/data-memory integrity checks and as a generic design_lib utility.

Parameters:
- NUM_BITS, 32, data word and checksum width.
- SEED, 0, NUM_BITS-wide initial accumulator value loaded at packet start.
- CNT_BITS, 8, width of the beat counter (max packet length 2^CNT_BITS - 1 beats).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  NUM_BITS  input word.
- in_last  in  1  final beat of packet; qualified by in_valid.
- out_valid  out  1  checksum available.
- out_ready  in  1  consumer accepts checksum.
- out_chksum  out  NUM_BITS  SEED XOR all words of the packet.
- out_err  out  1  beat counter saturated during the packet.

Behaviour:
- Reset: state=IDLE, acc=SEED, cnt=0, in_ready=0 during the reset cycle, out_valid=0, out_chksum=0, out_err=0. Reset mid-packet or mid-output discards everything; no partial checksum is emitted.
- FSM states:
  - IDLE: in_ready=1. An accepted beat (in_valid & in_ready) sets acc <= SEED ^ in_data and cnt <= 1. If in_last is also set, go to OUT; otherwise go to ACC.
  - ACC: in_ready=1. Each accepted beat sets acc <= acc ^ in_data and increments cnt. On an accepted beat with in_last, go to OUT.
  - OUT: in_ready=0. out_valid=1, out_chksum=acc. On out_valid & out_ready, go to IDLE and clear out_valid the next cycle.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: one beat per clock while in_valid is held. The output-hold stall costs at least one cycle per packet, because there is no skid between packets.
- Handshake rules:
  - Once out_valid is asserted, out_chksum and out_err stay stable until the transfer completes.
  - The producer holds in_data and in_last while in_valid=1 and in_ready=0.
- The XOR is computed by an instantiated dl_xor (NUM_BITS) with operands acc/SEED and in_data.
- Counter saturation: cnt saturates at 2^CNT_BITS-1. An accepted beat while cnt is saturated sets a sticky error flag; out_err mirrors it in OUT. The flag clears on return to IDLE.
- in_last without in_valid is ignored.
- Single-beat packet: out_chksum = SEED ^ word.

Optional Feature:
- Macro DL_XOR_CHKSUM_CNT_EN.
- When defined: adds output port out_cnt (CNT_BITS), the number of beats in the packet. It is valid with out_valid and held stable like out_chksum.
- When undefined: the port is absent. The counter is still kept internally for out_err.

Decomposition:
- Shared design_lib header: FSM state localparams (IDLE=2'd0, ACC=2'd1, OUT=2'd2) and include guard.
- One sub-module: dl_xor, instantiated for the fold.
- Registers are inline; no other sub-modules.

Test Plan:
- Reset, SEED=0: send 0x0000_00FF, 0x0000_0F0F, 0x1234_0000 (last on the third beat), out_ready=1.
  - out_chksum=0x1234_0FF0 one cycle after the third accept; out_err=0; out_cnt=3 when CNT_EN is defined.
- Single beat 0xDEAD_BEEF with in_last, SEED=0xFFFF_FFFF.
  - out_chksum=0x2152_4110; in_ready=0 while in OUT.
- Hold out_ready=0 for 5 cycles.
  - out_valid stays 1, out_chksum stays stable, in_ready=0.
  - Releasing out_ready returns to IDLE; the next packet starts cleanly from SEED.
- CNT_BITS=2: send 4 beats, last on the 4th.
  - out_err=1.
  - The next packet of 2 beats gives out_err=0.
- Assert rst mid-packet after 2 beats, then send a fresh 1-beat packet of 0x5.
  - No output from the aborted packet; out_chksum = SEED^0x5.
- Random in_valid gaps and out_ready back-pressure over 100 packets.
  - Checksums match the scoreboard XOR model.
